piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out serializer that produces the serial bit stream consumed by the 4-bit SIPO shift register stage. It accepts WIDTH-bit words over a valid/ready handshake and shifts each word out MSB first, one bit per enabled clock. Serial output and SIPO input use the same clock domain. With MSB-first order, after WIDTH enabled shifts the downstream SIPO holds the original word with its MSB in its top bit. Back-to-back words stream without gap bits.

## Interface
- WIDTH, 4, word width in bits; legal range 2..16.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk externally.
- in_valid  input  1  upstream presents a word on in_data.
- in_data  input  WIDTH  parallel word to serialize.
- in_ready  output  1  serializer can accept a word this cycle.
- ser_en  input  1  shift enable / pacing strobe; when low, all state holds.
- ser_data  output  1  current serial bit (MSB first); feeds SIPO data_in.
- ser_valid  output  1  ser_data carries a live bit.
- ser_last  output  1  ser_data is the LSB (final bit) of the current word.

## Operation
- State: 1-bit FSM {IDLE, SHIFT}, WIDTH-bit shift register shreg, bit counter cnt of width clog2(WIDTH).
- Outputs are decoded from registers only, so there is no in_data→ser_data combinational path.
  - ser_data = shreg[WIDTH-1].
  - ser_valid = (state==SHIFT).
  - ser_last = (state==SHIFT && cnt==WIDTH-1).
- in_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && ser_en). Combinational from state and ser_en; it does not depend on in_valid.
- Accept = in_valid && in_ready. On accept: shreg <= in_data, cnt <= 0, state <= SHIFT.
- IDLE: an accept moves to SHIFT; ser_en is not required to load from IDLE.
- SHIFT with ser_en=1 and cnt<WIDTH-1: shreg <= {shreg[WIDTH-2:0],1'b0}, cnt <= cnt+1.
- SHIFT with ser_en=1 and cnt==WIDTH-1:
  - If in_valid: reload (back-to-back); the next word's MSB appears on the following cycle.
  - Otherwise: state <= IDLE, shreg <= 0, cnt <= 0.
- SHIFT with ser_en=0: shreg, cnt and state hold. in_ready is 0 in this case unless state is IDLE.
- in_data is sampled only on the accepting edge. Later changes do not affect the word in flight.
- Reset (rst=0, any time, including mid-word): state=IDLE, shreg=0, cnt=0. A partially sent word is discarded and is not resumed.

## Timing
- Reset values: ser_data=0, ser_valid=0, ser_last=0, in_ready=1.
- Latency: a word accepted at edge k drives its MSB on ser_data during the cycle after edge k.
  - With ser_en held high, bit i (MSB=0) is valid after edge k+i.
  - ser_last is high after edge k+WIDTH-1.
- The downstream SIPO samples on edges k+1..k+WIDTH and holds the full word after edge k+WIDTH.
- Throughput: one word per WIDTH enabled cycles. Continuous in_valid gives zero idle bits between words.
- ser_en low stretches the current bit; ser_valid stays high and ser_data stays stable throughout.
- Simultaneous events:
  - Last bit + ser_en + in_valid → reload wins; no IDLE cycle.
  - Last bit + ser_en=0 + in_valid → no accept; the last bit is held.

## Test plan
- Reset: drive rst=0 mid-stream (SHIFT, cnt=2) with WIDTH=4 → ser_valid=0, ser_data=0, in_ready=1 immediately; the next accepted word starts from its MSB.
- Single word: in_data=4'b1011 accepted at edge k, ser_en=1 → ser_data 1,0,1,1 after edges k..k+3; ser_last only after edge k+3; downstream SIPO reads 4'b1011 after edge k+4; ser_valid=0 after edge k+4.
- Back-to-back: words 4'b1100 then 4'b0101 with in_valid held high → 8 consecutive valid bits 1,1,0,0,0,1,0,1; the second accept occurs at the ser_last cycle; ser_valid never drops.
- Stall: ser_en=0 for 3 cycles while bit 1 of 4'b1001 is on ser_data → ser_data=0 held for 3 extra cycles, cnt frozen, in_ready=0; the word completes correctly after ser_en=1.
- Last-bit stall: ser_en=0 at cnt=3 with in_valid=1 → no accept, in_ready=0; accept occurs on the first cycle with ser_en=1.
- Data change after accept: in_data changes on the cycle after accepting 4'b0110 → serial stream is still 0,1,1,0.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, MSB first, valid/ready word input.
// Feeds a downstream SIPO in the same clock domain; words stream gap-free.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ser_en,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;

  logic w_last;
  logic w_accept;

  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);
  assign in_ready = (r_state == IDLE) || (w_last && ser_en);
  assign w_accept = in_valid && in_ready;

  assign ser_data  = r_shreg[WIDTH-1];
  assign ser_valid = (r_state == SHIFT);
  assign ser_last  = w_last;

  // Accept takes priority so a reload on the last bit leaves no idle cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shreg <= in_data;
      r_cnt   <= '0;
    end else if (r_state == SHIFT && ser_en) begin
      if (w_last) begin
        r_state <= IDLE;
        r_shreg <= '0;
        r_cnt   <= '0;
      end else begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=4).
// A small SIPO model captures the serial stream for word-level checks.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       ser_en;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_last;

  logic [3:0] sipo;
  int errors;
  int checks;

  piso_serializer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ser_en   (ser_en),
    .ser_data (ser_data),
    .ser_valid(ser_valid),
    .ser_last (ser_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (ser_valid && ser_en)
      sipo <= {sipo[2:0], ser_data};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic d,
                         input logic v, input logic l);
    chk({tag, "_data"}, {7'd0, ser_data}, {7'd0, d});
    chk({tag, "_valid"}, {7'd0, ser_valid}, {7'd0, v});
    chk({tag, "_last"}, {7'd0, ser_last}, {7'd0, l});
  endtask

  initial begin
    logic [7:0] b2b;
    logic [3:0] w;
    errors   = 0;
    checks   = 0;
    sipo     = 4'h0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    ser_en   = 1'b0;
    repeat (2) tick();
    chk_bit("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_ready", {7'd0, in_ready}, 8'd1);
    rst = 1'b1;
    tick();

    // single word 1011
    in_data = 4'b1011; in_valid = 1'b1; ser_en = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 4'h0;
    chk_bit("single_b0", 1'b1, 1'b1, 1'b0);
    chk("single_ready0", {7'd0, in_ready}, 8'd0);
    tick(); chk_bit("single_b1", 1'b0, 1'b1, 1'b0);
    tick(); chk_bit("single_b2", 1'b1, 1'b1, 1'b0);
    tick(); chk_bit("single_b3", 1'b1, 1'b1, 1'b1);
    chk("single_ready3", {7'd0, in_ready}, 8'd1);
    tick();
    chk("single_valid_end", {7'd0, ser_valid}, 8'd0);
    chk("single_sipo", {4'd0, sipo}, 8'h0b);

    // back-to-back 1100, 0101
    b2b = 8'b1100_0101;
    in_data = 4'b1100; in_valid = 1'b1;
    tick();
    in_data = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if (i == 4) in_valid = 1'b0;
      chk_bit($sformatf("b2b_%0d", i), b2b[7-i], 1'b1, (i == 3 || i == 7));
      if (i == 3) chk("b2b_ready_last", {7'd0, in_ready}, 8'd1);
    end
    tick();
    chk("b2b_valid_end", {7'd0, ser_valid}, 8'd0);
    chk("b2b_sipo", {4'd0, sipo}, 8'h05);

    // stall on bit 1 of 1001
    in_data = 4'b1001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_bit("stall_b0", 1'b1, 1'b1, 1'b0);
    tick(); chk_bit("stall_b1", 1'b0, 1'b1, 1'b0);
    ser_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit($sformatf("stall_hold%0d", i), 1'b0, 1'b1, 1'b0);
      chk($sformatf("stall_ready%0d", i), {7'd0, in_ready}, 8'd0);
    end
    ser_en = 1'b1;
    tick(); chk_bit("stall_b2", 1'b0, 1'b1, 1'b0);
    tick(); chk_bit("stall_b3", 1'b1, 1'b1, 1'b1);
    tick();
    chk("stall_valid_end", {7'd0, ser_valid}, 8'd0);
    chk("stall_sipo", {4'd0, sipo}, 8'h09);

    // stall on the last bit with a word waiting
    in_data = 4'b0011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk_bit("lstall_b3", 1'b1, 1'b1, 1'b1);
    ser_en = 1'b0; in_valid = 1'b1; in_data = 4'b1110;
    #1;
    chk("lstall_ready", {7'd0, in_ready}, 8'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_bit($sformatf("lstall_hold%0d", i), 1'b1, 1'b1, 1'b1);
    end
    ser_en = 1'b1;
    #1;
    chk("lstall_ready_en", {7'd0, in_ready}, 8'd1);
    tick();
    in_valid = 1'b0;
    w = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk_bit($sformatf("lstall_w%0d", i), w[3-i], 1'b1, (i == 3));
    end
    tick();
    chk("lstall_sipo", {4'd0, sipo}, 8'h0e);

    // input changes after accept
    in_data = 4'b0110; in_valid = 1'b1;
    tick();
    in_data = 4'b1001; in_valid = 1'b0;
    w = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk_bit($sformatf("hold_in_%0d", i), w[3-i], 1'b1, (i == 3));
    end
    tick();
    chk("hold_in_sipo", {4'd0, sipo}, 8'h06);

    // reset mid-word at cnt=2
    in_data = 4'b1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk_bit("prerst_b2", 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk_bit("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst_ready", {7'd0, in_ready}, 8'd1);
    tick();
    rst = 1'b1;
    in_data = 4'b1010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    w = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk_bit($sformatf("postrst_%0d", i), w[3-i], 1'b1, (i == 3));
    end
    tick();
    chk("postrst_valid_end", {7'd0, ser_valid}, 8'd0);
    chk("postrst_sipo", {4'd0, sipo}, 8'h0a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
